// File: rtl/sme_rng_if.sv
// Seed/step handshake and lane outputs between the SME masking-randomness
// source and its controller/consumer.
interface sme_rng_if #(
    parameter int XLEN = 32,
    parameter int SMAX = 3
);
    localparam int RMAX = SMAX + SMAX * (SMAX - 1) / 2;

    logic                       seed_valid;
    logic                       seed_ready;
    logic [XLEN-1:0]            seed_data;
    logic                       reseed;
    logic                       step;
    logic [RMAX-1:0][XLEN-1:0]  rng;
    logic                       rng_valid;
    logic                       reseed_req;

    modport master (
        output seed_valid, seed_data, reseed, step,
        input  seed_ready, rng, rng_valid, reseed_req
    );

    modport slave (
        input  seed_valid, seed_data, reseed, step,
        output seed_ready, rng, rng_valid, reseed_req
    );
endinterface

// File: rtl/sme_rng.sv
// RMAX independent 32-bit Galois LFSR lanes feeding SME masking randomness;
// seeded word-by-word, stepped on demand, with a reseed budget.
module sme_rng #(
    parameter int XLEN       = 32,
    parameter int SMAX       = 3,
    parameter int RESEED_LOG = 16
) (
    input  logic     g_clk,
    input  logic     g_resetn,
    sme_rng_if.slave bus
);
    localparam int RMAX = SMAX + SMAX * (SMAX - 1) / 2;
    localparam int IDXW = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam int CNTW = RESEED_LOG + 1;
    localparam logic [CNTW-1:0] BUDGET   = {1'b1, {RESEED_LOG{1'b0}}};
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RMAX - 1);

    typedef enum logic [0:0] {
        ST_SEEDING = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    state_t                    state_r;
    logic [IDXW-1:0]           idx_r;
    logic [CNTW-1:0]           cnt_r;
    logic [CNTW-1:0]           cnt_next_s;
    logic                      seed_ready_r;
    logic                      rng_valid_r;
    logic                      reseed_req_r;
    logic [RMAX-1:0][XLEN-1:0] lane_r;
    logic                      seed_fire_s;
    logic                      step_fire_s;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    function automatic logic [XLEN-1:0] lfsr_next(input logic [XLEN-1:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? 32'h80200003 : 32'h00000000);
    endfunction

    // An all-zero lane would lock up, so zero seeds are replaced per lane
    function automatic logic [XLEN-1:0] seed_fix(input logic [XLEN-1:0] word,
                                                 input logic [IDXW-1:0] idx);
        seed_fix = (word == 32'h00000000) ? (32'h6A09E667 ^ 32'(idx)) : word;
    endfunction

    // Qualify handshakes; reseed overrides both seed beats and steps
    always_comb begin
        seed_fire_s = 1'b0;
        step_fire_s = 1'b0;
        if (bus.reseed) begin
            seed_fire_s = 1'b0;
            step_fire_s = 1'b0;
        end else if (state_r == ST_SEEDING) begin
            seed_fire_s = bus.seed_valid && seed_ready_r;
        end else begin
            step_fire_s = bus.step;
        end
    end

    // Saturating step budget counter, never wraps
    always_comb begin
        cnt_next_s = cnt_r;
        if (step_fire_s && (cnt_r != BUDGET)) begin
            cnt_next_s = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_r      <= ST_SEEDING;
            idx_r        <= {IDXW{1'b0}};
            cnt_r        <= {CNTW{1'b0}};
            seed_ready_r <= 1'b0;
            rng_valid_r  <= 1'b0;
            reseed_req_r <= 1'b0;
        end else if (bus.reseed) begin
            state_r      <= ST_SEEDING;
            idx_r        <= {IDXW{1'b0}};
            cnt_r        <= {CNTW{1'b0}};
            seed_ready_r <= 1'b1;
            rng_valid_r  <= 1'b0;
            reseed_req_r <= 1'b0;
        end else begin
            case (state_r)
                ST_SEEDING: begin
                    reseed_req_r <= 1'b0;
                    if (seed_fire_s && (idx_r == LAST_IDX)) begin
                        state_r      <= ST_RUN;
                        idx_r        <= {IDXW{1'b0}};
                        cnt_r        <= {CNTW{1'b0}};
                        seed_ready_r <= 1'b0;
                        rng_valid_r  <= 1'b1;
                    end else if (seed_fire_s) begin
                        idx_r        <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
                        seed_ready_r <= 1'b1;
                        rng_valid_r  <= 1'b0;
                    end else begin
                        seed_ready_r <= 1'b1;
                        rng_valid_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    seed_ready_r <= 1'b0;
                    rng_valid_r  <= 1'b1;
                    cnt_r        <= cnt_next_s;
                    reseed_req_r <= (cnt_next_s == BUDGET);
                end
                default: begin
                    state_r      <= ST_SEEDING;
                    idx_r        <= {IDXW{1'b0}};
                    cnt_r        <= {CNTW{1'b0}};
                    seed_ready_r <= 1'b0;
                    rng_valid_r  <= 1'b0;
                    reseed_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Lane state: loaded by seed beats, advanced together on step
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lane_r <= '0;
        end else if (seed_fire_s) begin
            lane_r[idx_r] <= seed_fix(bus.seed_data, idx_r);
        end else if (step_fire_s) begin
            for (int i = 0; i < RMAX; i++) begin
                lane_r[i] <= lfsr_next(lane_r[i]);
            end
        end else begin
            lane_r <= lane_r;
        end
    end

    assign bus.seed_ready = seed_ready_r;
    assign bus.rng        = lane_r;
    assign bus.rng_valid  = rng_valid_r;
    assign bus.reseed_req = reseed_req_r;
endmodule
